// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared bus types, write-back constants and ALU opcode
//               encodings for the byte-serial load/store unit, plus helpers
//               that classify an opcode (kind, access width, signedness).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  // Shared pipeline bus widths (RegBus / RegAddrBus / AluOpBus)
  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [7:0]  alu_op_bus_t;

  localparam reg_addr_bus_t NOP_REG_ADDR = 5'b00000;
  localparam reg_bus_t      ZERO_WORD    = 32'h0000_0000;

  // Opcode encodings shared with the decode/execute stages
  localparam alu_op_bus_t EXE_OR_OP  = 8'b0010_0101;
  localparam alu_op_bus_t EXE_ADD_OP = 8'b0010_0000;
  localparam alu_op_bus_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_bus_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_bus_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_bus_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_bus_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_bus_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_bus_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_bus_t EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } lsu_kind_e;

  function automatic lsu_kind_e op_kind(input alu_op_bus_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: op_kind = OP_LOAD;
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         op_kind = OP_STORE;
      default:                                                 op_kind = OP_ALU;
    endcase
  endfunction

  function automatic lsu_size_e op_size(input alu_op_bus_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
      default:                          op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input alu_op_bus_t op);
    op_signed = (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

  function automatic logic [2:0] size_bytes(input lsu_size_e s);
    case (s)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_if
// Description : Bundle of the LSU's pipeline-side and RAM-side signals.
//               master : pipeline/RAM environment (drives in_*, ram_din)
//               slave  : the LSU (drives ram_*, stallreq, wb_*)
// Ports       : in_valid/in_wd/in_wreg/in_wdata/in_aluop/in_mem_addr/in_reg2,
//               ram_addr/ram_we/ram_dout/ram_din, stallreq,
//               wb_valid/wb_wd/wb_wreg/wb_wdata
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic          in_valid;
  reg_addr_bus_t in_wd;
  logic          in_wreg;
  reg_bus_t      in_wdata;
  alu_op_bus_t   in_aluop;
  reg_bus_t      in_mem_addr;
  reg_bus_t      in_reg2;

  reg_bus_t      ram_addr;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  logic          stallreq;
  logic          wb_valid;
  reg_addr_bus_t wb_wd;
  logic          wb_wreg;
  reg_bus_t      wb_wdata;

  modport master (
    output in_valid, in_wd, in_wreg, in_wdata, in_aluop, in_mem_addr, in_reg2,
    output ram_din,
    input  ram_addr, ram_we, ram_dout,
    input  stallreq, wb_valid, wb_wd, wb_wreg, wb_wdata
  );

  modport slave (
    input  in_valid, in_wd, in_wreg, in_wdata, in_aluop, in_mem_addr, in_reg2,
    input  ram_din,
    output ram_addr, ram_we, ram_dout,
    output stallreq, wb_valid, wb_wd, wb_wreg, wb_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_lsu_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ext
// Description : Combinational sign/zero extender for loaded data.
//               Byte and halfword values are widened to 32 bits; words pass.
// Ports       : i_size   - access width
//               i_signed - 1 = sign-extend, 0 = zero-extend
//               i_raw    - assembled load data (low bytes significant)
//               o_ext    - 32-bit write-back value
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ext
  import mem_lsu_pkg::*;
(
  input  lsu_size_e i_size,
  input  logic      i_signed,
  input  reg_bus_t  i_raw,
  output reg_bus_t  o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_size)
      SZ_BYTE: o_ext = {{24{i_signed & i_raw[7]}},  i_raw[7:0]};
      SZ_HALF: o_ext = {{16{i_signed & i_raw[15]}}, i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Byte-serial load/store unit for an 8-bit RAM. Loads issue one
//               address per cycle and capture each byte one cycle later;
//               stores write one byte per cycle. Non-memory ops pass through
//               to write-back with one cycle of latency.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - mem_lsu_if.slave (pipeline inputs, RAM port, stall,
//                      write-back outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,    state_d;
  logic [2:0]    idx_q,      idx_d;      // LOAD: capture byte idx-1 / issue byte idx; STORE: byte being written
  lsu_size_e     size_q,     size_d;
  logic          sign_q,     sign_d;
  reg_addr_bus_t wd_q,       wd_d;
  logic          wreg_q,     wreg_d;
  reg_bus_t      base_q,     base_d;
  reg_bus_t      reg2_q,     reg2_d;
  reg_bus_t      buf_q,      buf_d;
  reg_bus_t      ram_addr_q, ram_addr_d;
  logic [7:0]    ram_dout_q, ram_dout_d;
  reg_addr_bus_t wb_wd_q,    wb_wd_d;
  logic          wb_wreg_q,  wb_wreg_d;
  reg_bus_t      wb_wdata_q, wb_wdata_d;

  logic          accept;
  logic          ram_we_c;
  logic          stall_c;
  lsu_kind_e     in_kind;
  lsu_size_e     in_size;
  logic [2:0]    nbytes;
  logic [1:0]    lane;
  reg_bus_t      load_word;
  reg_bus_t      load_ext;

  // Byte arriving this cycle belongs to the address issued last cycle.
  assign lane = 2'(idx_q - 3'd1);

  always_comb begin
    load_word = buf_q;
    load_word[{lane, 3'b000} +: 8] = bus.ram_din;
  end

  lsu_ext u_ext (
    .i_size   (size_q),
    .i_signed (sign_q),
    .i_raw    (load_word),
    .o_ext    (load_ext)
  );

  always_comb begin
    in_kind = op_kind(bus.in_aluop);
    in_size = op_size(bus.in_aluop);
    nbytes  = size_bytes(size_q);
    // DONE behaves like IDLE for a new request so back-to-back ops do not bubble.
    accept  = bus.in_valid && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d    = (state_q == S_DONE) ? S_IDLE : state_q;
    idx_d      = idx_q;
    size_d     = size_q;
    sign_d     = sign_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    base_d     = base_q;
    reg2_d     = reg2_q;
    buf_d      = buf_q;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ram_we_c   = 1'b0;
    stall_c    = 1'b0;

    if (accept) begin
      idx_d  = 3'd1;
      size_d = in_size;
      sign_d = op_signed(bus.in_aluop);
      wd_d   = bus.in_wd;
      wreg_d = bus.in_wreg;
      base_d = bus.in_mem_addr;
      reg2_d = bus.in_reg2;
      buf_d  = ZERO_WORD;
      case (in_kind)
        OP_LOAD: begin
          state_d    = S_LOAD;
          ram_addr_d = bus.in_mem_addr;
          stall_c    = 1'b1;
        end
        OP_STORE: begin
          ram_we_c   = 1'b1;
          ram_addr_d = bus.in_mem_addr;
          ram_dout_d = bus.in_reg2[7:0];
          stall_c    = 1'b1;
          if (in_size == SZ_BYTE) begin
            state_d    = S_DONE;
            wb_wd_d    = bus.in_wd;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = ZERO_WORD;
          end else begin
            state_d = S_STORE;
          end
        end
        default: begin
          state_d    = S_DONE;
          wb_wd_d    = bus.in_wd;
          wb_wreg_d  = bus.in_wreg;
          wb_wdata_d = bus.in_wdata;
        end
      endcase
    end else begin
      case (state_q)
        S_LOAD: begin
          stall_c = 1'b1;
          buf_d   = load_word;
          if (idx_q < nbytes) begin
            ram_addr_d = base_q + {29'd0, idx_q};   // wraps modulo 2^32
            idx_d      = idx_q + 3'd1;
          end else begin
            // Final byte captured this cycle; no further address issued.
            state_d    = S_DONE;
            wb_wd_d    = wd_q;
            wb_wreg_d  = wreg_q;
            wb_wdata_d = load_ext;
          end
        end
        S_STORE: begin
          stall_c    = 1'b1;
          ram_we_c   = 1'b1;
          ram_addr_d = base_q + {29'd0, idx_q};
          ram_dout_d = reg2_q[{idx_q[1:0], 3'b000} +: 8];
          if (idx_q == nbytes - 3'd1) begin
            state_d    = S_DONE;
            wb_wd_d    = wd_q;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = ZERO_WORD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to their reset values while rst is low so an
  // interrupted store cannot emit another write in the reset cycle.
  assign bus.ram_addr = rst ? ram_addr_d : ZERO_WORD;
  assign bus.ram_we   = rst & ram_we_c;
  assign bus.ram_dout = rst ? ram_dout_d : 8'h00;
  assign bus.stallreq = rst & stall_c;
  assign bus.wb_valid = rst & (state_q == S_DONE);
  assign bus.wb_wd    = rst ? wb_wd_q : NOP_REG_ADDR;
  assign bus.wb_wreg  = rst & wb_wreg_q;
  assign bus.wb_wdata = rst ? wb_wdata_q : ZERO_WORD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      size_q     <= SZ_BYTE;
      sign_q     <= 1'b0;
      wd_q       <= NOP_REG_ADDR;
      wreg_q     <= 1'b0;
      base_q     <= ZERO_WORD;
      reg2_q     <= ZERO_WORD;
      buf_q      <= ZERO_WORD;
      ram_addr_q <= ZERO_WORD;
      ram_dout_q <= 8'h00;
      wb_wd_q    <= NOP_REG_ADDR;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      base_q     <= base_d;
      reg2_q     <= reg2_d;
      buf_q      <= buf_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu. A vector table drives each
//               operation once; expected write-back records are queued at
//               drive time and popped when wb_valid appears. A byte RAM model
//               returns data one cycle after the address and logs writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_lsu_if bus ();

  mem_lsu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: rom_byte = 8'h78;
      32'h0000_0101: rom_byte = 8'h56;
      32'h0000_0102: rom_byte = 8'h34;
      32'h0000_0103: rom_byte = 8'h12;
      32'h0000_0003: rom_byte = 8'h80;
      default:       rom_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  logic [31:0] wr_addr_log [64];
  logic [7:0]  wr_data_log [64];
  int          wr_n = 0;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      if (wr_n < 64) begin
        wr_addr_log[wr_n] <= bus.ram_addr;
        wr_data_log[wr_n] <= bus.ram_dout;
      end
      wr_n <= wr_n + 1;
    end
    bus.ram_din <= rom_byte(bus.ram_addr);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    int          lat;
    bit          chk_data;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    alu_op_bus_t op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_data;
    int          lat;
    int          nbytes;
    bit          is_load;
    bit          is_store;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " stallreq"}, {31'd0, bus.stallreq}, 32'd0);
    check({tag, " wb_valid"}, {31'd0, bus.wb_valid}, 32'd0);
    check({tag, " wb_wreg"},  {31'd0, bus.wb_wreg},  32'd0);
    check({tag, " ram_we"},   {31'd0, bus.ram_we},   32'd0);
    check({tag, " wb_wd"},    {27'd0, bus.wb_wd},    32'd0);
    check({tag, " wb_wdata"}, bus.wb_wdata,          32'd0);
    check({tag, " ram_addr"}, bus.ram_addr,          32'd0);
    check({tag, " ram_dout"}, {24'd0, bus.ram_dout}, 32'd0);
  endtask

  task automatic drive(input alu_op_bus_t op, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [31:0] wdata,
                       input logic [4:0] wd, input logic wreg);
    bus.in_valid    = 1'b1;
    bus.in_aluop    = op;
    bus.in_mem_addr = addr;
    bus.in_reg2     = reg2;
    bus.in_wdata    = wdata;
    bus.in_wd       = wd;
    bus.in_wreg     = wreg;
  endtask

  task automatic push_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input int lat, input bit chk_data);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.lat = lat; e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  // Called on a cycle where wb_valid=1; k is the cycle offset from the origin.
  task automatic pop_check(input string tag, input int k);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_wb: got wb_valid at offset %0d expected none", tag, k);
    end else begin
      n_checks--;
      e = sb_q.pop_front();
      check({tag, " wb_latency"}, 32'(k), 32'(e.lat));
      check({tag, " wb_wreg"}, {31'd0, bus.wb_wreg}, {31'd0, e.wreg});
      if (e.chk_data) begin
        check({tag, " wb_wd"},    {27'd0, bus.wb_wd}, {27'd0, e.wd});
        check({tag, " wb_wdata"}, bus.wb_wdata, e.wdata);
      end
    end
  endtask

  function automatic vec_t mk(input alu_op_bus_t op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] wdata,
                              input logic [4:0] wd, input logic wreg,
                              input logic [31:0] exp_data, input int lat, input int nb,
                              input bit ld, input bit st);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.wdata = wdata; v.wd = wd; v.wreg = wreg;
    v.exp_data = exp_data; v.lat = lat; v.nbytes = nb; v.is_load = ld; v.is_store = st;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string       tag;
    int          n_stall;
    int          base_wr;
    bit          got;
    logic [31:0] r;
    tag     = $sformatf("v%0d", idx);
    n_stall = 0;
    got     = 1'b0;
    base_wr = wr_n;
    drive(v.op, v.addr, v.reg2, v.wdata, v.wd, v.wreg);
    push_exp(v.wd, v.is_store ? 1'b0 : v.wreg, v.exp_data, v.lat, !v.is_store);
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if (bus.stallreq) n_stall++;
      if (v.is_load && k < v.nbytes) begin
        check($sformatf("%s rd_addr%0d", tag, k), bus.ram_addr, v.addr + 32'(k));
        check($sformatf("%s rd_we%0d", tag, k), {31'd0, bus.ram_we}, 32'd0);
      end
      if (bus.wb_valid) begin
        pop_check(tag, k);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no wb_valid expected one within 16 cycles", tag);
      sb_q.delete();
    end
    check({tag, " stall_cycles"}, 32'(n_stall), (v.is_load || v.is_store) ? 32'(v.lat) : 32'd0);
    check({tag, " n_writes"}, 32'(wr_n - base_wr), v.is_store ? 32'(v.nbytes) : 32'd0);
    if (v.is_store) begin
      r = v.reg2;
      for (int i = 0; i < v.nbytes && (base_wr + i) < 64; i++) begin
        check($sformatf("%s wr_addr%0d", tag, i), wr_addr_log[base_wr + i], v.addr + 32'(i));
        check($sformatf("%s wr_data%0d", tag, i), {24'd0, wr_data_log[base_wr + i]}, {24'd0, r[8*i +: 8]});
      end
    end
  endtask

  initial begin
    int n_wb;
    int base_wr;

    vt[0]  = mk(EXE_ADD_OP, 32'h0,         32'h0,         32'h5,         5'd3,  1'b1, 32'h0000_0005, 1, 0, 0, 0);
    vt[1]  = mk(EXE_LW_OP,  32'h100,       32'h0,         32'h0,         5'd7,  1'b1, 32'h1234_5678, 5, 4, 1, 0);
    vt[2]  = mk(EXE_LB_OP,  32'h3,         32'h0,         32'h0,         5'd8,  1'b1, 32'hFFFF_FF80, 2, 1, 1, 0);
    vt[3]  = mk(EXE_LBU_OP, 32'h3,         32'h0,         32'h0,         5'd9,  1'b1, 32'h0000_0080, 2, 1, 1, 0);
    vt[4]  = mk(EXE_LH_OP,  32'h2,         32'h0,         32'h0,         5'd10, 1'b1, 32'hFFFF_80A7, 3, 2, 1, 0);
    vt[5]  = mk(EXE_LHU_OP, 32'h2,         32'h0,         32'h0,         5'd11, 1'b1, 32'h0000_80A7, 3, 2, 1, 0);
    vt[6]  = mk(EXE_LW_OP,  32'hFFFF_FFFE, 32'h0,         32'h0,         5'd12, 1'b1, 32'hA4A5_5A5B, 5, 4, 1, 0);
    vt[7]  = mk(EXE_SB_OP,  32'h10,        32'h1122_3344, 32'h0,         5'd13, 1'b1, 32'h0,         1, 1, 0, 1);
    vt[8]  = mk(EXE_SH_OP,  32'h201,       32'hAABB_CCDD, 32'h0,         5'd14, 1'b1, 32'h0,         2, 2, 0, 1);
    vt[9]  = mk(EXE_SW_OP,  32'h7,         32'hCAFE_BABE, 32'h0,         5'd15, 1'b1, 32'h0,         4, 4, 0, 1);
    vt[10] = mk(EXE_OR_OP,  32'h0,         32'h0,         32'hDEAD_BEEF, 5'd31, 1'b0, 32'hDEAD_BEEF, 1, 0, 0, 0);
    vt[11] = mk(EXE_LH_OP,  32'h102,       32'h0,         32'h0,         5'd16, 1'b1, 32'h0000_1234, 3, 2, 1, 0);

    rst = 1'b0;
    drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // in_valid while busy is ignored; address holds once idle
    drive(EXE_LW_OP, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1);
    push_exp(5'd5, 1'b1, 32'h1234_5678, 5, 1'b1);
    n_wb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.wb_valid) begin
        pop_check("busy", k);
        n_wb++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (k == 1) drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h99, 5'd6, 1'b1);
    end
    check("busy wb_count", 32'(n_wb), 32'd1);
    @(negedge clk);
    check("idle ram_addr_hold", bus.ram_addr, 32'h103);
    check("idle ram_we", {31'd0, bus.ram_we}, 32'd0);
    @(posedge clk);
    #1;

    // new op accepted in the DONE cycle
    drive(EXE_LB_OP, 32'h3, 32'h0, 32'h0, 5'd8, 1'b1);
    push_exp(5'd8, 1'b1, 32'hFFFF_FF80, 2, 1'b1);
    n_wb = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 2) check("done_accept stallreq", {31'd0, bus.stallreq}, 32'd0);
      if (bus.wb_valid) begin
        pop_check("done_accept", k);
        n_wb++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (k == 1) begin
        drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h9, 5'd4, 1'b1);
        push_exp(5'd4, 1'b1, 32'h9, 3, 1'b1);
      end
    end
    check("done_accept wb_count", 32'(n_wb), 32'd2);

    // reset in the middle of a word store
    base_wr = wr_n;
    drive(EXE_SW_OP, 32'h300, 32'h4433_2211, 32'h0, 5'd1, 1'b1);
    @(negedge clk);
    check("rst_sw b0 ram_we", {31'd0, bus.ram_we}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_sw b1 ram_dout", {24'd0, bus.ram_dout}, 32'h22);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_sw during");
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("rst_sw after");
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_wb = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.wb_valid || bus.ram_we) n_wb++;
      @(posedge clk);
      #1;
    end
    check("rst_sw no_activity", 32'(n_wb), 32'd0);
    check("rst_sw n_writes", 32'(wr_n - base_wr), 32'd2);
    check("rst_sw wr0 addr", wr_addr_log[base_wr], 32'h300);
    check("rst_sw wr0 data", {24'd0, wr_data_log[base_wr]}, 32'h11);
    check("rst_sw wr1 addr", wr_addr_log[base_wr + 1], 32'h301);
    check("rst_sw wr1 data", {24'd0, wr_data_log[base_wr + 1]}, 32'h22);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
